// File: rtl/draw_field_sync_pkg.sv
// Shared definitions for the draw-field update path: FSM state type and
// default geometry / flash timing.
package tetris_draw_pkg;

  localparam int FIELD_ROW_CNT       = 20;
  localparam int FIELD_COL_CNT       = 10;
  localparam int TETRIS_COLORS_WIDTH = 3;

  localparam int DEF_FLASH_FRAMES = 8;
  localparam int DEF_FLASH_PHASES = 6;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_VBL = 2'd1,
    S_FLASH    = 2'd2,
    S_DONE     = 2'd3
  } sync_state_t;

endpackage

// File: rtl/draw_field_sync_if.sv
// Game-logic side of draw_field_sync: snapshot handshake plus status.
interface draw_field_sync_if import tetris_draw_pkg::*; #(
  parameter int ROW_CNT = FIELD_ROW_CNT,
  parameter int COL_CNT = FIELD_COL_CNT,
  parameter int COLOR_W = TETRIS_COLORS_WIDTH
);
  logic                               gd_valid_i;
  logic                               gd_ready_o;
  logic [ROW_CNT*COL_CNT*COLOR_W-1:0] gd_field_i;
  logic [ROW_CNT-1:0]                 gd_clear_rows_i;
  logic [63:0]                        gd_next_data_i;
  logic [COLOR_W-1:0]                 gd_next_color_i;
  logic [1:0]                         gd_next_rot_i;
  logic                               gd_next_en_i;
  logic                               busy_o;
  logic                               done_o;

  // game core
  modport master (
    output gd_valid_i, gd_field_i, gd_clear_rows_i, gd_next_data_i,
           gd_next_color_i, gd_next_rot_i, gd_next_en_i,
    input  gd_ready_o, busy_o, done_o
  );

  // update controller
  modport slave (
    input  gd_valid_i, gd_field_i, gd_clear_rows_i, gd_next_data_i,
           gd_next_color_i, gd_next_rot_i, gd_next_en_i,
    output gd_ready_o, busy_o, done_o
  );
endinterface

// File: rtl/draw_field_sync_flash_timer.sv
// Frame/phase counters for the row-clear flash. Counts vblank ticks while
// enabled; o_finished fires combinationally on the tick that ends the last
// phase so the controller can leave FLASH on that same edge.
module flash_timer #(
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_PHASES = 6
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_tick,
  input  logic i_en,
  output logic o_phase_odd,
  output logic o_finished
);
  localparam int FRAME_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PHASE_W = $clog2(FLASH_PHASES + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FLASH_FRAMES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FLASH_PHASES - 1);

  logic [FRAME_W-1:0] r_frame;
  logic [PHASE_W-1:0] r_phase;
  logic               w_wrap;

  assign w_wrap      = i_en && i_tick && (r_frame == FRAME_LAST);
  assign o_phase_odd = r_phase[0];
  assign o_finished  = w_wrap && (r_phase == PHASE_LAST);

  // frame counter wraps each phase; phase stops at FLASH_PHASES (controller leaves)
  always_ff @(posedge clk) begin
    if (!rst_n || i_start) begin
      r_frame <= '0;
      r_phase <= '0;
    end else if (i_en && i_tick) begin
      if (r_frame == FRAME_LAST) begin
        r_frame <= '0;
        r_phase <= r_phase + 1'b1;
      end else begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end
endmodule

// File: rtl/draw_field_sync.sv
// Frame-synchronous update controller: stages a game snapshot, commits it at
// vblank start, optionally flashes cleared rows, then reports done.
module draw_field_sync import tetris_draw_pkg::*; #(
  parameter int ROW_CNT      = FIELD_ROW_CNT,
  parameter int COL_CNT      = FIELD_COL_CNT,
  parameter int COLOR_W      = TETRIS_COLORS_WIDTH,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES,
  parameter int FLASH_PHASES = DEF_FLASH_PHASES
)(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               vblank_start_i,
  draw_field_sync_if.slave                   gd,
  output logic [ROW_CNT*COL_CNT*COLOR_W-1:0] field_o,
  output logic [63:0]                        next_data_o,
  output logic [COLOR_W-1:0]                 next_color_o,
  output logic [1:0]                         next_rot_o,
  output logic                               next_en_o
);
  localparam int ROW_W   = COL_CNT * COLOR_W;
  localparam int FIELD_W = ROW_CNT * ROW_W;

  sync_state_t r_state, w_state_nxt;
  logic r_ready, r_done;
  logic w_accept, w_commit, w_start, w_phase_odd, w_finished, w_blank;

  logic [FIELD_W-1:0] r_stg_field, r_dsp_field, w_field;
  logic [ROW_CNT-1:0] r_stg_clear, r_dsp_clear;
  logic [63:0]        r_stg_ndata, r_dsp_ndata;
  logic [COLOR_W-1:0] r_stg_ncolor, r_dsp_ncolor;
  logic [1:0]         r_stg_nrot, r_dsp_nrot;
  logic               r_stg_nen, r_dsp_nen;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: if (gd.gd_valid_i && r_ready) begin
        w_accept    = 1'b1;
        w_state_nxt = S_WAIT_VBL;
      end
      S_WAIT_VBL: if (vblank_start_i) begin
        w_commit = 1'b1;
        if (r_stg_clear == '0) w_state_nxt = S_DONE;
        else begin
          w_start     = 1'b1;
          w_state_nxt = S_FLASH;
        end
      end
      S_FLASH: if (w_finished) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // registered handshake/status: ready mirrors "next state is IDLE", done
  // trails the DONE state by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= (r_state == S_DONE);
    end
  end

  // staging capture on accept, display commit at vblank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stg_field  <= '0;
      r_stg_clear  <= '0;
      r_stg_ndata  <= '0;
      r_stg_ncolor <= '0;
      r_stg_nrot   <= '0;
      r_stg_nen    <= 1'b0;
      r_dsp_field  <= '0;
      r_dsp_clear  <= '0;
      r_dsp_ndata  <= '0;
      r_dsp_ncolor <= '0;
      r_dsp_nrot   <= '0;
      r_dsp_nen    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_stg_field  <= gd.gd_field_i;
        r_stg_clear  <= gd.gd_clear_rows_i;
        r_stg_ndata  <= gd.gd_next_data_i;
        r_stg_ncolor <= gd.gd_next_color_i;
        r_stg_nrot   <= gd.gd_next_rot_i;
        r_stg_nen    <= gd.gd_next_en_i;
      end
      if (w_commit) begin
        r_dsp_field  <= r_stg_field;
        r_dsp_clear  <= r_stg_clear;
        r_dsp_ndata  <= r_stg_ndata;
        r_dsp_ncolor <= r_stg_ncolor;
        r_dsp_nrot   <= r_stg_nrot;
        r_dsp_nen    <= r_stg_nen;
      end
    end
  end

  flash_timer #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_PHASES (FLASH_PHASES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start),
    .i_tick      (vblank_start_i),
    .i_en        (r_state == S_FLASH),
    .o_phase_odd (w_phase_odd),
    .o_finished  (w_finished)
  );

  assign w_blank = (r_state == S_FLASH) && !w_phase_odd;

  // blank flashing rows during even phases
  always_comb begin
    w_field = r_dsp_field;
    for (int r = 0; r < ROW_CNT; r++)
      if (w_blank && r_dsp_clear[r]) w_field[r*ROW_W +: ROW_W] = '0;
  end

  assign field_o       = w_field;
  assign next_data_o   = r_dsp_ndata;
  assign next_color_o  = r_dsp_ncolor;
  assign next_rot_o    = r_dsp_nrot;
  assign next_en_o     = r_dsp_nen;
  assign gd.gd_ready_o = r_ready;
  assign gd.busy_o     = (r_state != S_IDLE);
  assign gd.done_o     = r_done;
endmodule
